// File: rtl/gray_codec_pipe_if.sv
// Stream bundle for gray_codec_pipe: an input stream of {mode,data} words
// and an output stream of converted words with their step-error flag.
//
// Handshake: a word moves across a stream only on a posedge where valid and
// ready are both high. The producer keeps valid and its payload steady until
// that transfer. Ready may depend combinationally on the consumer's state,
// but never on valid of the same stream.
interface gray_codec_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
    logic             out_step_err;

    // Source/sink side: drives the input stream and sinks the results
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_step_err
    );

    // Converter side
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_step_err
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage pipelined binary<->Gray converter.
// Each word selects its own direction (mode 0 = bin->gray, 1 = gray->bin).
// S1 registers the accepted word. The conversion runs between S1 and S2.
// S2 drives the output stream. Both stages advance at once, so the block
// sustains one word per cycle.
// Optional feature macro: GRAY_STEP_CHECK_EN. When it is defined, the block
// flags each gray->bin input that is not exactly one bit away from the
// previous gray->bin input.
module gray_codec_pipe #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    gray_codec_pipe_if.slave  bus
);

    logic             s1_valid;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_data;
    logic             s2_valid;
    logic             s2_mode;
    logic [WIDTH-1:0] s2_data;
    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] conv_data;

    // Prefix XOR from the MSB down recovers the binary value from the Gray code
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage advance: a stage may load when it is empty or its content moves on
    always_comb begin
        s2_adv = !s2_valid || bus.out_ready;
        s1_adv = !s1_valid || s2_adv;
    end

    assign bus.in_ready = s1_adv;
    assign in_fire      = bus.in_valid && s1_adv;

    // Conversion between S1 and S2, selected by the word's own mode bit
    always_comb begin
        conv_data = s1_data ^ (s1_data >> 1);
        if (s1_mode) begin
            conv_data = gray_to_bin(s1_data);
        end
    end

    // S1: capture the incoming word whenever the stage can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mode <= bus.in_mode;
                s1_data <= bus.in_data;
            end
        end
    end

    // S2: register the converted result; hold it while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_data <= conv_data;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_mode  = s2_mode;
    assign bus.out_data  = s2_data;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_code;
    logic             prev_vld;
    logic             in_err;
    logic             s1_err;
    logic             s2_err;

    // A legal Gray step changes exactly one bit; a repeated code is also an error
    always_comb begin
        in_err = bus.in_mode && prev_vld && ($countones(bus.in_data ^ prev_code) != 1);
    end

    // History of the last accepted gray->bin code; bin->gray words leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_code <= '0;
            prev_vld  <= 1'b0;
        end else if (in_fire && bus.in_mode) begin
            prev_code <= bus.in_data;
            prev_vld  <= 1'b1;
        end
    end

    // Error flag travels alongside its word through both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err <= 1'b0;
            s2_err <= 1'b0;
        end else begin
            if (s1_adv && bus.in_valid) begin
                s1_err <= in_err;
            end
            if (s2_adv && s1_valid) begin
                s2_err <= s1_err;
            end
        end
    end

    assign bus.out_step_err = s2_valid && s2_err;
`else
    assign bus.out_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Testbench for gray_codec_pipe. It runs directed cases first and then a
// randomized stream. A reference model computes what each output word must be.
// A small WIDTH=1 instance exercises the identity case.
`timescale 1ns/1ps
module tb_gray_codec_pipe;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gray_codec_pipe_if #(.WIDTH(W)) bus ();
    gray_codec_pipe_if #(.WIDTH(1)) bus1 ();

    gray_codec_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    gray_codec_pipe #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_byte(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic         mode;
        logic [W-1:0] data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] inv_tbl [0:255];
    logic [W-1:0] data_log[$];
    logic         err_log[$];
    logic         log_en = 1'b0;
    logic [1:0]   w1_q[$];
`ifdef GRAY_STEP_CHECK_EN
    logic [W-1:0] hist_code;
    logic         hist_vld = 1'b0;
`endif

    // Gray->binary by inverting the forward mapping over all 256 codes
    initial begin
        for (int b = 0; b < 256; b++) begin
            inv_tbl[8'(b ^ (b >> 1))] = 8'(b);
        end
    end

    function automatic int bits_set(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n++;
        return n;
    endfunction

    // Scoreboard: push accepted words, compare every cycle a result is visible
    always @(negedge clk) begin
        exp_t e;
        logic ov_exp;
        if (rst) begin
            exp_q.delete();
`ifdef GRAY_STEP_CHECK_EN
            hist_vld = 1'b0;
`endif
        end else begin
            check_bit("in_ready", bus.in_ready, (exp_q.size() < 2) || bus.out_ready);
            ov_exp = (exp_q.size() > 0) && ((cyc - exp_q[0].cyc) >= 2);
            check_bit("out_valid", bus.out_valid, ov_exp);
            if (bus.out_valid && exp_q.size() > 0) begin
                check_byte("out_data", bus.out_data, exp_q[0].data);
                check_bit("out_mode", bus.out_mode, exp_q[0].mode);
                check_bit("out_step_err", bus.out_step_err, exp_q[0].err);
                if (bus.out_ready) begin
                    if (log_en) begin
                        data_log.push_back(bus.out_data);
                        err_log.push_back(bus.out_step_err);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.mode = bus.in_mode;
                e.cyc  = cyc;
                e.err  = 1'b0;
                if (!bus.in_mode) begin
                    e.data = bus.in_data ^ (bus.in_data >> 1);
                end else begin
                    e.data = inv_tbl[bus.in_data];
`ifdef GRAY_STEP_CHECK_EN
                    if (hist_vld && bits_set(bus.in_data ^ hist_code) != 1) e.err = 1'b1;
                    hist_code = bus.in_data;
                    hist_vld  = 1'b1;
`endif
                end
                exp_q.push_back(e);
            end
        end
    end

    // WIDTH=1 instance: both directions are the identity
    always @(negedge clk) begin
        if (rst) begin
            w1_q.delete();
        end else begin
            if (bus1.out_valid) begin
                if (w1_q.size() == 0) begin
                    check_bit("w1_spurious", bus1.out_valid, 1'b0);
                end else begin
                    check_bit("w1_data", bus1.out_data[0], w1_q[0][0]);
                    check_bit("w1_mode", bus1.out_mode, w1_q[0][1]);
                    if (bus1.out_ready) void'(w1_q.pop_front());
                end
            end
            if (bus1.in_valid && bus1.in_ready) w1_q.push_back({bus1.in_mode, bus1.in_data[0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Present one word and hold it until accepted; waited = cycles presented
    task automatic send(input logic m, input logic [W-1:0] d, output int waited);
        logic took;
        took   = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        while (!took && waited < 100) begin
            @(negedge clk);
            took = bus.in_ready;
            step();
            waited++;
        end
        bus.in_valid = 1'b0;
        check_bit("send_accept", took, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           w;
        logic         acc;
        logic [W-1:0] gcnt;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_mode    = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_mode   = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;
        gcnt           = '0;
        idle(3);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_byte("rst_out_data", bus.out_data, 8'h00);
        check_bit("rst_out_mode", bus.out_mode, 1'b0);
        check_bit("rst_step_err", bus.out_step_err, 1'b0);
        step();

        // single bin->gray word, latency two cycles
        send(1'b0, 8'h2D, w);
        @(negedge clk);
        check_bit("t1_early", bus.out_valid, 1'b0);
        @(negedge clk);
        check_bit("t1_valid", bus.out_valid, 1'b1);
        check_byte("t1_data", bus.out_data, 8'h3B);
        check_bit("t1_mode", bus.out_mode, 1'b0);
        step();

        // single gray->bin word
        send(1'b1, 8'h3B, w);
        @(negedge clk);
        @(negedge clk);
        check_bit("t2_valid", bus.out_valid, 1'b1);
        check_byte("t2_data", bus.out_data, 8'h2D);
        check_bit("t2_mode", bus.out_mode, 1'b1);
        step();

        // back-to-back stream, every word accepted on first presentation
        for (int i = 0; i < 256; i++) begin
            send(1'b0, 8'(i), w);
            if (w != 1) check_bit("t3_no_stall", 1'b0, 1'b1);
        end
        idle(4);

        // backpressure: two words enter, third waits, head holds
        data_log.delete();
        err_log.delete();
        log_en = 1'b1;
        bus.out_ready = 1'b0;
        send(1'b0, 8'h01, w);
        send(1'b0, 8'h02, w);
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b0;
        bus.in_data  = 8'h03;
        repeat (4) begin
            @(negedge clk);
            check_bit("t4_in_ready", bus.in_ready, 1'b0);
            check_bit("t4_out_valid", bus.out_valid, 1'b1);
            check_byte("t4_hold", bus.out_data, 8'h01);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_bit("t4_release", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        idle(5);
        check_bit("t4_count", data_log.size() == 3, 1'b1);
        if (data_log.size() == 3) begin
            check_byte("t4_res0", data_log[0], 8'h01);
            check_byte("t4_res1", data_log[1], 8'h03);
            check_byte("t4_res2", data_log[2], 8'h02);
        end

        // reset with two words in flight
        bus.out_ready = 1'b0;
        send(1'b1, 8'h10, w);
        send(1'b1, 8'h20, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_bit("t5_out_valid", bus.out_valid, 1'b0);
        check_bit("t5_in_ready", bus.in_ready, 1'b1);
        check_byte("t5_out_data", bus.out_data, 8'h00);
        check_bit("t5_out_mode", bus.out_mode, 1'b0);
        check_bit("t5_step_err", bus.out_step_err, 1'b0);
        step();
        bus.out_ready = 1'b1;
        send(1'b0, 8'h2D, w);
        @(negedge clk);
        @(negedge clk);
        check_bit("t5_next_valid", bus.out_valid, 1'b1);
        check_byte("t5_next_data", bus.out_data, 8'h3B);
        step();

        // Gray step check after reset cleared the history
        data_log.delete();
        err_log.delete();
        send(1'b1, 8'h00, w);
        send(1'b1, 8'h01, w);
        send(1'b1, 8'h03, w);
        send(1'b1, 8'h00, w);
        idle(5);
        check_bit("t6_count", err_log.size() == 4, 1'b1);
        if (err_log.size() == 4) begin
            check_byte("t6_d2", data_log[2], 8'h02);
            check_bit("t6_err0", err_log[0], 1'b0);
            check_bit("t6_err1", err_log[1], 1'b0);
            check_bit("t6_err2", err_log[2], 1'b0);
`ifdef GRAY_STEP_CHECK_EN
            check_bit("t6_err3", err_log[3], 1'b1);
`else
            check_bit("t6_err3", err_log[3], 1'b0);
`endif
        end
        log_en = 1'b0;

        // randomized interleaved traffic with random backpressure
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            step();
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.in_mode  = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom_range(0, 255));
                if (bus.in_mode && $urandom_range(0, 1) == 1) begin
                    bus.in_data = gcnt ^ (gcnt >> 1);
                    gcnt++;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);
        check_bit("rand_drain", exp_q.size() == 0, 1'b1);

        // WIDTH=1 identity stream
        for (int k = 0; k < 24; k++) begin
            bus1.in_valid = 1'b1;
            bus1.in_mode  = 1'($urandom_range(0, 1));
            bus1.in_data  = 1'($urandom_range(0, 1));
            step();
        end
        bus1.in_valid = 1'b0;
        idle(4);
        check_bit("w1_drain", w1_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
